// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sequencer for a time-multiplexed FP FIR sharing one pipelined ALU
// Ports: clk/rst; in_valid_i/in_ready_o sample handshake; out_valid_o/out_ready_i result
// handshake; cfg_we_i/cfg_addr_i coefficient write, cfg_err_o dropped-write pulse;
// dmem/cmem/regf en/we/addr; alu_en_o pipeline advance, alu_op_o, alu_sel_a_o/alu_sel_b_o; busy_o.
module fir_seq_ctrl #(
  parameter int TAPS = 64,
  parameter int ALU_LAT = 5,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  input  logic          cfg_we_i,
  input  logic [AW-1:0] cfg_addr_i,
  output logic          cfg_err_o,
  output logic          dmem_en_o,
  output logic          dmem_we_o,
  output logic [AW-1:0] dmem_addr_o,
  output logic          cmem_en_o,
  output logic          cmem_we_o,
  output logic [AW-1:0] cmem_addr_o,
  output logic          regf_en_o,
  output logic          regf_we_o,
  output logic [AW-1:0] regf_addr_o,
  output logic          alu_en_o,
  output logic [1:0]    alu_op_o,
  output logic [1:0]    alu_sel_a_o,
  output logic [1:0]    alu_sel_b_o,
  output logic          busy_o
);
  typedef enum logic [2:0] {IDLE, MUL, MWAIT, ACC, AWAIT, RED, DONE} state_e;
  localparam logic [AW-1:0] T_M1 = AW'(TAPS - 1);
  localparam logic [AW-1:0] LAT = AW'(ALU_LAT);
  localparam logic [AW-1:0] LAT_M1 = AW'(ALU_LAT - 1);
  localparam logic [AW-1:0] TAIL = AW'(TAPS - ALU_LAT - 1);
  localparam logic [AW:0] T_EXT = (AW+1)'(TAPS);
  state_e        state_q;
  logic [AW-1:0] cnt_q, rnd_q, head_q;
  logic [1:0]    op_q, sel_a_q, sel_b_q;
  logic          accept, red_rd, mul_wr, await_wr;
  logic [AW:0]   diff;
  assign in_ready_o  = state_q == IDLE || (state_q == DONE && out_ready_i);
  assign accept      = in_valid_i && in_ready_o;
  assign red_rd      = state_q == RED && cnt_q == '0 && rnd_q != LAT;
  assign diff        = {1'b0, head_q} - {1'b0, cnt_q};
  assign out_valid_o = state_q == DONE;
  assign busy_o      = state_q != IDLE;
  assign alu_en_o    = state_q != IDLE && state_q != DONE;
  assign cfg_err_o   = cfg_we_i && (state_q != IDLE || in_valid_i);
  assign alu_op_o    = op_q;
  assign alu_sel_a_o = sel_a_q;
  assign alu_sel_b_o = sel_b_q;
  // newest-first sample walk: (head - cnt) mod TAPS
  assign dmem_en_o   = accept || state_q == MUL;
  assign dmem_we_o   = accept;
  assign dmem_addr_o = accept ? head_q :
                       state_q == MUL ? (diff[AW] ? AW'(diff + T_EXT) : diff[AW-1:0]) : '0;
  assign cmem_we_o   = state_q == IDLE && cfg_we_i && !in_valid_i;
  assign cmem_en_o   = cmem_we_o || state_q == MUL;
  assign cmem_addr_o = cmem_we_o ? cfg_addr_i : state_q == MUL ? cnt_q : '0;
  // product k lands ALU_LAT+1 cycles after its address cycle; the last ALU_LAT+1 land in MWAIT
  assign mul_wr      = state_q == MUL && cnt_q > LAT;
  assign await_wr    = state_q == AWAIT && cnt_q != '0;
  assign regf_we_o   = mul_wr || state_q == MWAIT || await_wr;
  assign regf_en_o   = regf_we_o || state_q == ACC || red_rd;
  assign regf_addr_o = mul_wr ? cnt_q - LAT - 1'b1 :
                       state_q == MWAIT ? cnt_q + TAIL :
                       state_q == ACC ? cnt_q :
                       await_wr ? cnt_q - 1'b1 :
                       red_rd ? rnd_q : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rnd_q   <= '0;
      head_q  <= '0;
      op_q    <= '0;
      sel_a_q <= '0;
      sel_b_q <= '0;
    end else begin
      op_q    <= state_q == MUL ? 2'b10 : (state_q == ACC || red_rd) ? 2'b11 : 2'b00;
      sel_a_q <= state_q == MUL ? 2'd1 :
                 state_q == ACC ? (cnt_q < LAT ? 2'd0 : 2'd2) :
                 (red_rd && rnd_q != '0) ? 2'd2 : 2'd0;
      sel_b_q <= state_q == MUL ? 2'd1 : (state_q == ACC || red_rd) ? 2'd2 : 2'd0;
      case (state_q)
        IDLE, DONE:
          if (accept) begin
            state_q <= MUL;
            cnt_q   <= '0;
          end else if (state_q == DONE && out_ready_i) state_q <= IDLE;
        MUL:
          if (cnt_q == T_M1) begin
            state_q <= MWAIT;
            cnt_q   <= '0;
            head_q  <= head_q == T_M1 ? '0 : head_q + 1'b1;
          end else cnt_q <= cnt_q + 1'b1;
        MWAIT:
          if (cnt_q == LAT) begin
            state_q <= ACC;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        ACC:
          if (cnt_q == T_M1) begin
            state_q <= AWAIT;
            cnt_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        AWAIT:
          if (cnt_q == LAT) begin
            state_q <= RED;
            cnt_q   <= '0;
            rnd_q   <= '0;
          end else cnt_q <= cnt_q + 1'b1;
        // one extra cycle after the last round lets the final sum reach the ALU output
        RED:
          if (rnd_q == LAT) state_q <= DONE;
          else if (cnt_q == LAT_M1) begin
            cnt_q <= '0;
            rnd_q <= rnd_q + 1'b1;
          end else cnt_q <= cnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
